// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C slave (7-bit address) in front of a byte-wide register
// file. An 8-bit pointer auto-increments across read and write bursts. SCL and
// SDA are oversampled on wb_clk through a synchroniser and a glitch filter.
// Optional feature macro: I2C_SLAVE_WP_EN adds a write-protect input wp_i.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h45,
  parameter int         MEM_AW     = 4,
  parameter int         FILT_LEN   = 3
) (
  input  logic              wb_clk,
  input  logic              wb_rst_n,
  input  logic              scl_i,
  input  logic              sda_i,
`ifdef I2C_SLAVE_WP_EN
  input  logic              wp_i,
`endif
  output logic              sda_oen_o,
  output logic              busy_o,
  output logic              wr_strobe_o,
  output logic [MEM_AW-1:0] wr_addr_o
);

  localparam int                DEPTH   = 2**MEM_AW;
  localparam logic [MEM_AW-1:0] PTR_ONE = MEM_AW'(1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK
  } state_t;

  state_t state, state_nxt;

  logic                scl_p0, scl_p1, sda_p0, sda_p1;
  logic [FILT_LEN-1:0] scl_hist, sda_hist;
  logic                scl_f, sda_f, scl_d, sda_d;
  logic                scl_rise, scl_fall, start_ev, stop_ev;

  logic [2:0]        bit_cnt;
  logic              ack_rise, rw;
  logic [7:0]        shift_r, tx_byte, rx_byte;
  logic              last_bit, addr_hit, wr_allow;
  logic [MEM_AW-1:0] ptr, ptr_nxt;
  logic [7:0]        mem [DEPTH];

  logic bit_tick, byte_done, ack_drive, ack_seen, ack_done;
  logic tx_drive, rack_rel, rd_next, rd_start, busy_set, busy_clr;
  logic ptr_load, wr_byte, mem_we;

`ifdef I2C_SLAVE_WP_EN
  assign wr_allow = ~wp_i;
`else
  assign wr_allow = 1'b1;
`endif

  // Two-flop synchroniser on both bus lines; idle bus level is high.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
    end else begin
      scl_p0 <= scl_i;
      scl_p1 <= scl_p0;
      sda_p0 <= sda_i;
      sda_p1 <= sda_p0;
    end
  end

  // Glitch filter: a filtered line moves only when the last FILT_LEN samples agree.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      scl_hist <= '1;
      sda_hist <= '1;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[FILT_LEN-2:0], scl_p1};
      sda_hist <= {sda_hist[FILT_LEN-2:0], sda_p1};
      if (&scl_hist)       scl_f <= 1'b1;
      else if (~|scl_hist) scl_f <= 1'b0;
      if (&sda_hist)       sda_f <= 1'b1;
      else if (~|sda_hist) sda_f <= 1'b0;
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  assign scl_rise = scl_f & ~scl_d;
  assign scl_fall = ~scl_f & scl_d;
  assign start_ev = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_ev  = scl_f & scl_d & ~sda_d & sda_f;

  assign rx_byte  = {shift_r[6:0], sda_f};
  assign last_bit = (bit_cnt == 3'd7);
  assign addr_hit = (rx_byte[7:1] == SLAVE_ADDR);
  assign ptr_nxt  = ptr + PTR_ONE;

  // FSM state register.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  // FSM next state; STOP and START override any bit event.
  always_comb begin
    state_nxt = state;
    if (stop_ev) begin
      state_nxt = IDLE;
    end else if (start_ev) begin
      state_nxt = ADDR;
    end else begin
      case (state)
        ADDR:     if (scl_rise && last_bit) state_nxt = addr_hit ? ADDR_ACK : IDLE;
        ADDR_ACK: if (scl_fall && ack_rise) state_nxt = rw ? RDATA : PTR;
        PTR:      if (scl_rise && last_bit) state_nxt = PTR_ACK;
        PTR_ACK:  if (scl_fall && ack_rise) state_nxt = WDATA;
        WDATA:    if (scl_rise && last_bit) state_nxt = WACK;
        WACK:     if (scl_fall && ack_rise) state_nxt = WDATA;
        RDATA:    if (scl_rise && last_bit) state_nxt = RACK;
        RACK:     if (scl_rise)             state_nxt = sda_f ? IDLE : RDATA;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // FSM outputs: per-clock control strobes decoded from state and bus events.
  always_comb begin
    bit_tick  = 1'b0;
    byte_done = 1'b0;
    ack_drive = 1'b0;
    ack_seen  = 1'b0;
    ack_done  = 1'b0;
    tx_drive  = 1'b0;
    rack_rel  = 1'b0;
    rd_next   = 1'b0;
    busy_set  = 1'b0;
    busy_clr  = 1'b0;
    if (stop_ev) begin
      busy_clr = 1'b1;
    end else if (!start_ev) begin
      case (state)
        ADDR, PTR, WDATA: begin
          bit_tick  = scl_rise;
          byte_done = scl_rise & last_bit;
        end
        ADDR_ACK, PTR_ACK, WACK: begin
          ack_drive = scl_fall & ~ack_rise;
          ack_seen  = scl_rise;
          ack_done  = scl_fall & ack_rise;
        end
        RDATA: begin
          bit_tick = scl_rise;
          tx_drive = scl_fall;
        end
        RACK: begin
          rack_rel = scl_fall;
          rd_next  = scl_rise & ~sda_f;
          busy_clr = scl_rise & sda_f;
        end
        default: ;
      endcase
      if (state == ADDR && byte_done) begin
        busy_set = addr_hit;
        busy_clr = ~addr_hit;
      end
    end
  end

  assign rd_start = ack_done & (state == ADDR_ACK) & rw;
  assign ptr_load = byte_done & (state == PTR);
  assign wr_byte  = byte_done & (state == WDATA);
  assign mem_we   = wr_byte & wr_allow;

  // Bit counter, ACK-phase tracking and captured R/W bit.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      bit_cnt  <= '0;
      ack_rise <= 1'b0;
      rw       <= 1'b0;
    end else if (start_ev || stop_ev) begin
      bit_cnt  <= '0;
      ack_rise <= 1'b0;
    end else begin
      if (bit_tick)     bit_cnt <= bit_cnt + 3'd1;
      else if (rd_next) bit_cnt <= '0;
      if (ack_seen)      ack_rise <= 1'b1;
      else if (ack_done) ack_rise <= 1'b0;
      if (byte_done && state == ADDR) rw <= sda_f;
    end
  end

  // Receive shift register and transmit byte holding register (data only).
  always_ff @(posedge wb_clk) begin
    if (bit_tick) shift_r <= rx_byte;
    if (rd_start)     tx_byte <= mem[ptr];
    else if (rd_next) tx_byte <= mem[ptr_nxt];
  end

  // Pointer, register file and write strobe.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ptr         <= '0;
      wr_strobe_o <= 1'b0;
      wr_addr_o   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_strobe_o <= mem_we;
      if (mem_we) begin
        mem[ptr]  <= rx_byte;
        wr_addr_o <= ptr;
      end
      if (ptr_load)              ptr <= rx_byte[MEM_AW-1:0];
      else if (wr_byte || rd_next) ptr <= ptr_nxt;
    end
  end

  // SDA drive and busy flag; SDA only changes on SCL falls, START, STOP or reset.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      sda_oen_o <= 1'b1;
      busy_o    <= 1'b0;
    end else begin
      if (start_ev || stop_ev) sda_oen_o <= 1'b1;
      else if (ack_drive)      sda_oen_o <= 1'b0;
      else if (rd_start)       sda_oen_o <= mem[ptr][7];
      else if (ack_done)       sda_oen_o <= 1'b1;
      else if (tx_drive)       sda_oen_o <= tx_byte[3'd7 - bit_cnt];
      else if (rack_rel)       sda_oen_o <= 1'b1;
      if (busy_set)      busy_o <= 1'b1;
      else if (busy_clr) busy_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Testbench for i2c_slave_regfile: bit-banged I2C master, transaction-level
// register file model, directed and randomized bursts.
module tb_i2c_slave_regfile;

  localparam int H = 12;

  logic       wb_clk = 1'b0;
  logic       wb_rst_n;
  logic       scl_m, sda_m;
  logic       sda_bus;
  logic       sda_oen_o, busy_o, wr_strobe_o;
  logic [3:0] wr_addr_o;
  bit         wp_model = 1'b0;
`ifdef I2C_SLAVE_WP_EN
  logic       wp_i;
  assign wp_i = wp_model;
`endif

  assign sda_bus = sda_m & sda_oen_o;

  always #5 wb_clk = ~wb_clk;

  i2c_slave_regfile dut (
    .wb_clk      (wb_clk),
    .wb_rst_n    (wb_rst_n),
    .scl_i       (scl_m),
    .sda_i       (sda_bus),
`ifdef I2C_SLAVE_WP_EN
    .wp_i        (wp_i),
`endif
    .sda_oen_o   (sda_oen_o),
    .busy_o      (busy_o),
    .wr_strobe_o (wr_strobe_o),
    .wr_addr_o   (wr_addr_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: byte array, pointer, expected write-strobe addresses.
  logic [7:0] ref_mem [16];
  int         ref_ptr;
  int         exp_wr[$];
  int         obs_wr[$];
  logic [7:0] wq[$];

  always @(negedge wb_clk)
    if (wb_rst_n && wr_strobe_o) obs_wr.push_back(int'(wr_addr_o));

  initial begin
    #950000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag);
    chk({tag, "_nstrobe"}, obs_wr.size(), exp_wr.size());
    for (int k = 0; k < exp_wr.size() && k < obs_wr.size(); k++)
      chk({tag, "_wr_addr"}, obs_wr[k], exp_wr[k]);
    exp_wr.delete();
    obs_wr.delete();
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) ref_mem[k] = 8'h00;
    ref_ptr = 0;
    exp_wr.delete();
    obs_wr.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge wb_clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(H);
    scl_m = 1'b1; tick(H);
    sda_m = 1'b0; tick(H);
    scl_m = 1'b0; tick(H);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(H);
    scl_m = 1'b1; tick(H);
    sda_m = 1'b1; tick(H);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    sda_m = b; tick(H);
    scl_m = 1'b1;
    if (glitch) begin
      tick(4); scl_m = 1'b0; tick(2); scl_m = 1'b1; tick(H - 6);
    end else begin
      tick(H);
    end
    scl_m = 1'b0; tick(H);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; tick(H);
    scl_m = 1'b1; tick(H / 2);
    b = sda_bus;  tick(H / 2);
    scl_m = 1'b0; tick(H);
  endtask

  task automatic write_byte(input logic [7:0] d, input int gbit, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i], i == gbit);
    recv_bit(ack);
  endtask

  task automatic read_byte(input logic mnack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(mnack, 1'b0);
  endtask

  // Write burst of wq to pointer byte p; glitch on bit gbit of byte gbyte.
  task automatic do_write(input logic [7:0] p, input int gbyte, input int gbit);
    logic ack;
    i2c_start();
    write_byte(8'h8A, -1, ack);
    chk("wr_addr_ack", ack, 0);
    chk("wr_busy", busy_o, 1);
    write_byte(p, -1, ack);
    chk("wr_ptr_ack", ack, 0);
    ref_ptr = int'(p) % 16;
    for (int k = 0; k < wq.size(); k++) begin
      write_byte(wq[k], (k == gbyte) ? gbit : -1, ack);
      chk("wr_data_ack", ack, 0);
      if (!wp_model) begin
        ref_mem[ref_ptr] = wq[k];
        exp_wr.push_back(ref_ptr);
      end
      ref_ptr = (ref_ptr + 1) % 16;
    end
    i2c_stop();
    chk("wr_busy_after_stop", busy_o, 0);
    chk("wr_oen_after_stop", sda_oen_o, 1);
    check_wr("wr");
  endtask

  // Set pointer, repeated START, read n bytes (ACK all but the last).
  task automatic do_read(input logic [7:0] p, input int n);
    logic       ack;
    logic [7:0] d;
    i2c_start();
    write_byte(8'h8A, -1, ack);
    chk("rd_addr_ack", ack, 0);
    write_byte(p, -1, ack);
    chk("rd_ptr_ack", ack, 0);
    ref_ptr = int'(p) % 16;
    i2c_start();
    write_byte(8'h8B, -1, ack);
    chk("rd_addr2_ack", ack, 0);
    chk("rd_busy", busy_o, 1);
    for (int k = 0; k < n; k++) begin
      read_byte(k == n - 1, d);
      chk("rd_data", d, ref_mem[ref_ptr]);
      if (k != n - 1) ref_ptr = (ref_ptr + 1) % 16;
    end
    chk("rd_busy_after_nack", busy_o, 0);
    i2c_stop();
    check_wr("rd");
  endtask

  initial begin
    logic       ack;
    logic [7:0] b8;
    logic [7:0] p;
    int         n;

    wb_rst_n = 1'b0;
    scl_m    = 1'b1;
    sda_m    = 1'b1;
    model_reset();
    tick(3);
    chk("rst_oen", sda_oen_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_strobe", wr_strobe_o, 0);
    chk("rst_wr_addr", wr_addr_o, 0);
    wb_rst_n = 1'b1;
    tick(10);

    // Directed burst write then readback.
    wq.delete(); wq.push_back(8'h11); wq.push_back(8'h22); wq.push_back(8'h33);
    do_write(8'h02, -1, -1);
    do_read(8'h02, 3);

    // Pointer wrap on write and on read.
    wq.delete(); wq.push_back(8'hAA); wq.push_back(8'hBB);
    do_write(8'h0F, -1, -1);
    do_read(8'h0F, 2);

    // Address mismatch: NACK, not busy, no writes.
    i2c_start();
    write_byte(8'h90, -1, ack);
    chk("mismatch_nack", ack, 1);
    chk("mismatch_busy", busy_o, 0);
    i2c_stop();
    check_wr("mismatch");

    // Abort with STOP after 4 bits of the second data byte.
    i2c_start();
    write_byte(8'h8A, -1, ack);
    chk("abort_addr_ack", ack, 0);
    write_byte(8'h07, -1, ack);
    chk("abort_ptr_ack", ack, 0);
    write_byte(8'h5C, -1, ack);
    chk("abort_d0_ack", ack, 0);
    ref_mem[7] = 8'h5C;
    exp_wr.push_back(7);
    b8 = 8'hE3;
    for (int i = 7; i >= 4; i--) send_bit(b8[i], 1'b0);
    i2c_stop();
    chk("abort_oen", sda_oen_o, 1);
    chk("abort_busy", busy_o, 0);
    check_wr("abort");
    do_read(8'h07, 2);

    // SCL glitch inside a data bit must not add a bit.
    wq.delete(); wq.push_back(8'hC6);
    do_write(8'h03, 0, 4);
    do_read(8'h03, 1);

    // Randomized bursts, pointer upper bits random.
    for (int it = 0; it < 5; it++) begin
      wq.delete();
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
      p = 8'($urandom);
      do_write(p, -1, -1);
      do_read(8'($urandom), $urandom_range(1, 4));
    end

`ifdef I2C_SLAVE_WP_EN
    // Write protect: ACKed but not stored, no strobe, pointer still moves.
    wp_model = 1'b1;
    wq.delete(); wq.push_back(8'h55); wq.push_back(8'h66);
    do_write(8'h05, -1, -1);
    wp_model = 1'b0;
    do_read(8'h05, 2);
`endif

    // Reset asserted while the slave drives the address ACK.
    i2c_start();
    b8 = 8'h8A;
    for (int i = 7; i >= 0; i--) send_bit(b8[i], 1'b0);
    chk("ack_driven", sda_oen_o, 0);
    wb_rst_n = 1'b0;
    #1;
    chk("rst_mid_oen", sda_oen_o, 1);
    chk("rst_mid_busy", busy_o, 0);
    model_reset();
    scl_m = 1'b1;
    sda_m = 1'b1;
    tick(3);
    chk("rst_mid_wr_addr", wr_addr_o, 0);
    wb_rst_n = 1'b1;
    tick(10);
    do_read(8'h00, 3);
    wq.delete(); wq.push_back(8'($urandom)); wq.push_back(8'($urandom));
    do_write(8'h0E, -1, -1);
    do_read(8'h0E, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
- I2C slave register file on the same SCL/SDA bus that the system's I2C master drives. It is the downstream target of that master and provides the bench-side device at address 0x45.
- Supports 7-bit addressing, an 8-bit register pointer, pointer auto-increment, and multi-byte read and write bursts.
- Oversamples SCL and SDA on the system clock. No separate bus clock domain.

Parameters:
- SLAVE_ADDR, 7'h45, 7-bit I2C device address the block responds to.
- MEM_AW, 4, register file address width; depth is 2**MEM_AW bytes.
- FILT_LEN, 3, glitch filter length in clocks. A filtered line changes only after FILT_LEN consecutive equal samples.

Ports:
- wb_clk  in  1  system clock; sole clock.
- wb_rst_n  in  1  reset, asynchronous assert, active-low.
- scl_i  in  1  SCL line as sampled from the pad.
- sda_i  in  1  SDA line as sampled from the pad.
- sda_oen_o  out  1  SDA output enable, active-low. 0 drives SDA low; 1 releases it. The pad logic is an open drain.
- busy_o  out  1  high from an address-matched START until STOP or NACK.
- wr_strobe_o  out  1  one-clock pulse when a data byte is written into the file.
- wr_addr_o  out  MEM_AW  file address of the latest write.

Behaviour:
- Reset values: sda_oen_o=1, busy_o=0, wr_strobe_o=0, wr_addr_o=0, pointer=0, FSM=IDLE. Register file contents are cleared to 0.
- Input path: 2-flop synchroniser, then the FILT_LEN filter. Filtered SCL/SDA reset to 1.
- Event detection, evaluated on the filtered lines:
  - scl_rise and scl_fall are single-clock pulses.
  - START is SDA falling while SCL=1. STOP is SDA rising while SCL=1.
  - START and STOP take precedence over bit events in the same clock.
- Bit timing:
  - SDA is sampled on scl_rise.
  - sda_oen_o is updated only on scl_fall. It is never changed while SCL is high, except by reset, STOP or START, all of which release it.
- Shift register: 8 bits, MSB first. The bit counter is 0..7, and the 8th scl_rise completes a byte.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK.
  - IDLE -> ADDR on START.
  - ADDR, byte complete:
    - Byte[7:1]==SLAVE_ADDR: go to ADDR_ACK and drive ACK (oen=0) on the next scl_fall. busy_o=1.
    - Mismatch: return to IDLE and leave SDA released.
  - ADDR_ACK, on the following scl_fall: release SDA.
    - R/W bit=0 -> PTR.
    - R/W bit=1 -> RDATA. Load mem[pointer] and drive its MSB on the same scl_fall.
  - PTR, byte complete: pointer<=byte[MEM_AW-1:0], upper bits ignored. Go to PTR_ACK, ACK, then WDATA.
  - WDATA, byte complete:
    - mem[pointer]<=byte; wr_strobe_o pulses; wr_addr_o<=pointer.
    - pointer increments modulo 2**MEM_AW (wraps 0xF->0x0 at MEM_AW=4).
    - Go to WACK, ACK, then WDATA.
  - RDATA: drive the bits on scl_fall. After the 8th bit, release SDA and go to RACK.
  - RACK, on scl_rise:
    - Master ACK (SDA=0): pointer++ with wrap, load the next byte, go to RDATA.
    - Master NACK: go to IDLE, busy_o=0.
- Repeated START in any state: return to ADDR and clear the bit counter. The pointer is preserved, so the write-pointer-then-read sequence works.
- STOP in any state: go to IDLE, sda_oen_o=1, busy_o=0. A partial byte is discarded and not written.
- Reset asserted mid-transfer: all state returns to reset values immediately (asynchronous). SDA is released.
- Latency: the ACK drive begins on the scl_fall after the 8th scl_rise. wr_strobe_o fires in the clock after the 8th scl_rise of a data byte.

Optional Feature:
- Macro I2C_SLAVE_WP_EN.
- Defined:
  - Adds input port wp_i (1 bit). When wp_i=1, WDATA bytes are still ACKed, but the file is not written, wr_strobe_o does not pulse, and the pointer still increments.
  - The pointer byte itself is unaffected by wp_i.
- Undefined: no wp_i port; writes are always stored.

Test Plan:
- Write burst: START, 0x8A, ptr 0x02, data 0x11 0x22 0x33, STOP -> ACK on all 5 bytes; mem[2..4]=0x11,0x22,0x33; three wr_strobe_o pulses with wr_addr_o=2,3,4.
- Pointer wrap with random read:
  - START, 0x8A, ptr 0x0F, data 0xAA 0xBB, STOP -> mem[15]=0xAA, mem[0]=0xBB.
  - Then START, 0x8A, ptr 0x0F, Sr, 0x8B; read two bytes with master ACK then NACK -> SDA returns 0xAA then 0xBB. busy_o falls after the NACK.
- Address mismatch: START, 0x90 -> SDA stays released on the 9th clock (NACK); busy_o stays 0; no memory change.
- Abort: STOP after 4 data bits of the 2nd write byte -> 1st byte stored, 2nd not stored; FSM in IDLE; sda_oen_o=1.
- Filter: 2-clock low glitch on SCL with FILT_LEN=3 -> no bit counted. Asserting wb_rst_n=0 during ACK -> sda_oen_o=1 in the same cycle.
- With I2C_SLAVE_WP_EN and wp_i=1: write 0x55 to ptr 0x05 -> byte is ACKed; mem[5] unchanged; no wr_strobe_o pulse.
